// File: rtl/seg_scan_capture.sv
`timescale 1ns/1ps
// seg_scan_capture: samples a multiplexed HC4511 7-segment scan bus and
// reassembles complete 4-digit BCD frames, flagging blanking and protocol faults.
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 1,
  parameter int TIMEOUT       = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  Seg,
  input  logic [3:0]  Sel,
  output logic [15:0] Digits,
  output logic [3:0]  Blank,
  output logic        Valid,
  output logic        Err,
  output logic [1:0]  ErrCode,
  output logic        Stale
);

  typedef enum logic [1:0] {WAIT0, GOT0, GOT1, GOT2} state_t;

  state_t      state;
  logic [3:0]  in_sel, prev_sel;
  logic [7:0]  in_seg, prev_seg;
  logic [7:0]  stab_cnt, stab_next;
  logic        held, held_eff, gap, accept;
  logic        acc_fire;
  logic [3:0]  acc_sel;
  logic [6:0]  acc_seg;
  logic [3:0]  dec_val;
  logic        dec_blank, seg_ok;
  logic [1:0]  sel_idx;
  logic        sel_ok;
  logic [15:0] idle_cnt;
  logic [11:0] part_val;
  logic [2:0]  part_blank;

  // Dwell tracking: one acceptance per Sel dwell once the sample has been stable long enough
  always_comb begin
    gap       = (in_sel == 4'b1111);
    stab_next = 8'd1;
    if (gap)
      stab_next = 8'd0;
    else if (in_sel == prev_sel && in_seg == prev_seg)
      stab_next = (stab_cnt == 8'hFF) ? stab_cnt : stab_cnt + 8'd1;
    held_eff = held && (in_sel == prev_sel);
    accept   = !gap && !held_eff && (stab_next == 8'(STABLE_CYCLES));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_sel   <= 4'b1111;
      in_seg   <= 8'h00;
      prev_sel <= 4'b1111;
      prev_seg <= 8'h00;
      stab_cnt <= 8'd0;
      held     <= 1'b0;
      acc_fire <= 1'b0;
      acc_sel  <= 4'b1111;
      acc_seg  <= 7'd0;
    end else begin
      in_sel   <= Sel;
      in_seg   <= Seg;
      prev_sel <= in_sel;
      prev_seg <= in_seg;
      stab_cnt <= stab_next;
      held     <= accept | held_eff;
      acc_fire <= accept;
      acc_sel  <= in_sel;
      acc_seg  <= in_seg[6:0];
    end
  end

  always_comb begin
    dec_val   = 4'hF;
    dec_blank = 1'b0;
    seg_ok    = 1'b1;
    case (acc_seg)
      7'b0111111: dec_val = 4'd0;
      7'b0000110: dec_val = 4'd1;
      7'b1011011: dec_val = 4'd2;
      7'b1001111: dec_val = 4'd3;
      7'b1100110: dec_val = 4'd4;
      7'b1101101: dec_val = 4'd5;
      7'b1111100: dec_val = 4'd6;
      7'b0000111: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1100111: dec_val = 4'd9;
      7'b0000000: dec_blank = 1'b1;
      default:    seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    sel_idx = 2'd0;
    sel_ok  = 1'b1;
    case (acc_sel)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  // Frame assembly; digit0 always (re)starts a frame, a mid-frame digit0 is also a sequence fault
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= WAIT0;
      Digits     <= 16'h0000;
      Blank      <= 4'b1111;
      Valid      <= 1'b0;
      Err        <= 1'b0;
      ErrCode    <= 2'b00;
      Stale      <= 1'b0;
      idle_cnt   <= 16'd0;
      part_val   <= 12'd0;
      part_blank <= 3'd0;
    end else begin
      Valid <= 1'b0;
      Err   <= 1'b0;
      if (acc_fire) begin
        idle_cnt <= 16'd0;
        if (!sel_ok) begin
          Err     <= 1'b1;
          ErrCode <= 2'b11;
          state   <= WAIT0;
        end else if (!seg_ok) begin
          Err     <= 1'b1;
          ErrCode <= 2'b01;
          state   <= WAIT0;
        end else if (sel_idx == 2'd0) begin
          part_val[3:0] <= dec_val;
          part_blank[0] <= dec_blank;
          state         <= GOT0;
          if (state != WAIT0) begin
            Err     <= 1'b1;
            ErrCode <= 2'b10;
          end
        end else begin
          case (state)
            GOT0:
              if (sel_idx == 2'd1) begin
                part_val[7:4] <= dec_val;
                part_blank[1] <= dec_blank;
                state         <= GOT1;
              end else begin
                Err     <= 1'b1;
                ErrCode <= 2'b10;
                state   <= WAIT0;
              end
            GOT1:
              if (sel_idx == 2'd2) begin
                part_val[11:8] <= dec_val;
                part_blank[2]  <= dec_blank;
                state          <= GOT2;
              end else begin
                Err     <= 1'b1;
                ErrCode <= 2'b10;
                state   <= WAIT0;
              end
            GOT2:
              if (sel_idx == 2'd3) begin
                Digits <= {dec_val, part_val};
                Blank  <= {dec_blank, part_blank};
                Valid  <= 1'b1;
                Stale  <= 1'b0;
                state  <= WAIT0;
              end else begin
                Err     <= 1'b1;
                ErrCode <= 2'b10;
                state   <= WAIT0;
              end
            default: ;
          endcase
        end
      end else if (idle_cnt == 16'(TIMEOUT - 1)) begin
        idle_cnt <= 16'(TIMEOUT);
        state    <= WAIT0;
        Stale    <= 1'b1;
      end else if (idle_cnt != 16'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the multiplexed 4-digit 7-segment scan driver. It samples the time-multiplexed segment bus (Seg) and active-low digit selects (Sel), decodes each HC4511 segment pattern back to BCD, and reassembles complete 4-digit frames. It sits on the board-test/verification path, either looped back from the display pins or fed from the driver's outputs in the same clock domain, and reports the displayed value, blanking, and protocol errors.

## Interface
Parameters:
- STABLE_CYCLES, 1, consecutive identical (Sel,Seg) samples required to accept a digit; legal range 1..255.
- TIMEOUT, 1024, cycles without an accepted digit before a partial frame is discarded and Stale is set; legal range 4..65535.

Ports:
- Clk  input  1  clock.
- Rst  input  1  reset, asynchronous, active-high.
- Seg  input  8  segments, active-high; bit0=a … bit6=g, bit7=dp (ignored).
- Sel  input  4  digit select, active-low; 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3.
- Digits  output  16  last complete frame; digit n in [4n+3:4n].
- Blank  output  4  per-digit blank flag of last complete frame.
- Valid  output  1  one-cycle pulse when Digits/Blank update.
- Err  output  1  one-cycle pulse on a detected fault.
- ErrCode  output  2  fault cause, held until the next Err: 01 illegal segment pattern, 10 sequence error, 11 illegal select.
- Stale  output  1  high after a timeout; cleared by the next Valid.

## Operation
- Input stage: Sel and Seg are registered once (in_reg). All decisions use in_reg.
- Stability: the counter increments when in_reg equals the previous in_reg. It resets to 1 on any change. A digit is accepted once per dwell, when the count reaches STABLE_CYCLES. No re-acceptance until Sel changes.
- Sel=1111 is a gap. It is never accepted, resets the stability counter, and is not an error.
- Sel with more than one zero bit is an illegal select. On acceptance: Err, ErrCode=11, partial frame discarded, state to WAIT0.
- Segment decode (bits g..a), HC4511 glyphs:
  - 0=0111111
  - 1=0000110
  - 2=1011011
  - 3=1001111
  - 4=1100110
  - 5=1101101
  - 6=1111100 (no tail)
  - 7=0000111
  - 8=1111111
  - 9=1100111 (no tail)
  - 0000000 decodes to blank: value 4'hF, blank bit = 1.
- Any other pattern is illegal: Err, ErrCode=01, partial frame discarded, state to WAIT0.
- States:
  - WAIT0: only digit0 is accepted. Acceptance stores the slot and moves to GOT0. Accepted digit1..3 are silently ignored; this is normal sync-up, not an error.
  - GOT0 → GOT1 → GOT2: each state accepts only the next digit in order.
  - Accepting digit3 in GOT2 loads all four slots into Digits/Blank atomically, pulses Valid, clears Stale, and returns to WAIT0.
  - In GOT0..GOT2, acceptance of the wrong digit is a sequence error: Err, ErrCode=10. If the wrong digit is digit0, it is stored and the state moves to GOT0 (resync). Otherwise the state moves to WAIT0.
- Timeout: the idle counter clears on every acceptance. When it reaches TIMEOUT: partial frame discarded, state to WAIT0, Stale=1, no Err. Digits/Blank keep their last values.
- Faults of the same cycle are prioritized: illegal select > illegal segment > sequence.

## Timing
- Reset values: Digits=16'h0000, Blank=4'b1111, Valid=0, Err=0, ErrCode=00, Stale=0, state WAIT0, in_reg Sel=1111, Seg=00, counters 0.
- Rst takes effect immediately, including mid-frame. The partial frame is lost and no Valid or Err is emitted.
- Acceptance edge: STABLE_CYCLES edges after the edge that first captures a new (Sel,Seg) into in_reg.
- Valid, Err, Digits, Blank, and ErrCode are registered and change on the edge after the acceptance edge. Latency from Sel/Seg input to output is STABLE_CYCLES+1 edges.
- With STABLE_CYCLES=1 and a 1-cycle-per-digit driver, one frame completes every 4 cycles. Valid pulses every 4 cycles in steady state.
- Valid and Err are never high in the same cycle.

## Test plan
- Reset, then drive digits 4,3,3,3 (Sel 1110/1101/1011/0111, one cycle each, STABLE_CYCLES=1) → first Valid 2 edges after digit3 is sampled; Digits=16'h3334, Blank=0000; Valid repeats every 4 cycles.
- Start the stream at digit2 → digits 2 and 3 are ignored without Err; the first Valid carries the full next frame.
- Digit1 pattern 0110110 → Err with ErrCode=01, no Valid for that frame; Digits keep 16'h3334.
- Order 0,2 → Err with ErrCode=10. Order 0,1,0 → Err with ErrCode=10, resync at GOT0, next 1,2,3 → Valid.
- STABLE_CYCLES=3 with a 1-cycle Seg glitch during a 4-cycle dwell → glitch not accepted, correct digit accepted, no Err. Sel=0011 held for 3 cycles → ErrCode=11.
- TIMEOUT=16, stop after digit1 (Sel=1111) → Stale=1 at the 16th idle cycle, no Err; next full frame → Valid, Stale=0. Rst asserted mid-frame → all outputs at reset values immediately.
